// File: rtl/dual_port_ram.sv
// dual_port_ram: 64 x 8 true dual-port synchronous RAM with one shared clock.
// Both ports can read or write any location on every cycle. Read data is
// registered, so it appears one cycle after the address is sampled.
//
// Ports:
//   clk      - clock; every state change happens on the rising edge except reset
//   rst_n    - asynchronous active-low reset; clears the outputs and blocks writes
//   data_p1  - port 1 write data       data_p2  - port 2 write data
//   addr_p1  - port 1 address          addr_p2  - port 2 address
//   wr_p1    - port 1 write enable     wr_p2    - port 2 write enable
//   out_p1   - port 1 read data        out_p2   - port 2 read data
//
// Optional feature macro: DPRAM_BYPASS_EN
//   defined   - write-first: a port that reads the address the other port is
//               writing in the same cycle gets the new data.
//   undefined - read-first: that port gets the contents from before the write.
// Memory contents are not reset.

module dual_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_p1,
  input  logic [ADDR_WIDTH-1:0] addr_p1,
  input  logic                  wr_p1,
  input  logic [DATA_WIDTH-1:0] data_p2,
  input  logic [ADDR_WIDTH-1:0] addr_p2,
  input  logic                  wr_p2,
  output logic [DATA_WIDTH-1:0] out_p1,
  output logic [DATA_WIDTH-1:0] out_p2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_p1;
  logic [DATA_WIDTH-1:0] rd_p2;
  logic                  same_addr;
  logic                  wr_p2_ok;

  assign same_addr = (addr_p1 == addr_p2);
  // On a write-write collision port 1 wins; port 2's write is dropped.
  assign wr_p2_ok  = wr_p2 && !(wr_p1 && same_addr);

  // The memory array is not reset. Writes are still gated by rst_n, so no
  // write lands on an edge where reset is held.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (wr_p1) begin
        mem[addr_p1] <= data_p1;
      end
      if (wr_p2_ok) begin
        mem[addr_p2] <= data_p2;
      end
    end
  end

  // Read data for each port. With forwarding enabled, a port takes the other
  // port's write data when both use the same address in the same cycle. A port
  // that is writing never updates its own output, so a write-write collision
  // has no read path and forwarding never needs to handle it.
  always_comb begin
    rd_p1 = mem[addr_p1];
    rd_p2 = mem[addr_p2];
`ifdef DPRAM_BYPASS_EN
    if (wr_p2 && same_addr) begin
      rd_p1 = data_p2;
    end
    if (wr_p1 && same_addr) begin
      rd_p2 = data_p1;
    end
`endif
  end

  // Each output register loads only on a read cycle and holds its value
  // while its port is writing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p1 <= '0;
      out_p2 <= '0;
    end else begin
      if (!wr_p1) begin
        out_p1 <= rd_p1;
      end
      if (!wr_p2) begin
        out_p2 <= rd_p2;
      end
    end
  end

endmodule

// File: tb/tb_dual_port_ram.sv
module tb_dual_port_ram;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_p1;
  logic [5:0] addr_p1;
  logic       wr_p1;
  logic [7:0] data_p2;
  logic [5:0] addr_p2;
  logic       wr_p2;
  logic [7:0] out_p1;
  logic [7:0] out_p2;

  dual_port_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_p1 (data_p1),
    .addr_p1 (addr_p1),
    .wr_p1   (wr_p1),
    .data_p2 (data_p2),
    .addr_p2 (addr_p2),
    .wr_p2   (wr_p2),
    .out_p1  (out_p1),
    .out_p2  (out_p2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DPRAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string      name;
    logic       wr1;
    logic [5:0] a1;
    logic [7:0] d1;
    logic       wr2;
    logic [5:0] a2;
    logic [7:0] d2;
    logic [7:0] e1;  // expected out_p1 when port 1 reads
    logic [7:0] e2;  // expected out_p2 when port 2 reads
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] e1;
    logic [7:0] e2;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];
  int   n_tests;
  int   n_fail;
  logic [7:0] held1;
  logic [7:0] held2;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, got, exp);
    end
  endtask

  task automatic drive(input logic w1, input logic [5:0] a1, input logic [7:0] d1,
                       input logic w2, input logic [5:0] a2, input logic [7:0] d2);
    wr_p1 = w1; addr_p1 = a1; data_p1 = d1;
    wr_p2 = w2; addr_p2 = a2; data_p2 = d2;
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = sb.pop_front();
      check({e.name, "/p1"}, out_p1, e.e1);
      check({e.name, "/p2"}, out_p2, e.e2);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{"ww_concurrent",  1'b1, 6'h01, 8'h45, 1'b1, 6'h02, 8'h32, 8'h00, 8'h00};
    vecs[1] = '{"w1_r2",          1'b1, 6'h03, 8'h24, 1'b0, 6'h01, 8'h00, 8'h00, 8'h45};
    vecs[2] = '{"rr_concurrent",  1'b0, 6'h02, 8'h00, 1'b0, 6'h03, 8'h00, 8'h32, 8'h24};
    vecs[3] = '{"rw_coll_p1rd",   1'b0, 6'h02, 8'h00, 1'b1, 6'h02, 8'h10,
                BYP ? 8'h10 : 8'h32, 8'h00};
    vecs[4] = '{"rr_same_addr",   1'b0, 6'h02, 8'h00, 1'b0, 6'h02, 8'h00, 8'h10, 8'h10};
    vecs[5] = '{"ww_coll",        1'b1, 6'h3F, 8'hAA, 1'b1, 6'h3F, 8'h55, 8'h00, 8'h00};
    vecs[6] = '{"rd_after_wwcol", 1'b0, 6'h3F, 8'h00, 1'b0, 6'h3F, 8'h00, 8'hAA, 8'hAA};
    vecs[7] = '{"rw_coll_p2rd",   1'b1, 6'h3F, 8'h5A, 1'b0, 6'h3F, 8'h00,
                8'h00, BYP ? 8'h5A : 8'hAA};
    vecs[8] = '{"r1_w2",          1'b0, 6'h3F, 8'h00, 1'b1, 6'h05, 8'h11, 8'h5A, 8'h00};

    // Asynchronous reset with random inputs; writes must stay blocked.
    rst_n = 1'b1;
    drive(1'b0, 6'h00, 8'h00, 1'b0, 6'h00, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    check("reset_async/p1", out_p1, 8'h00);
    check("reset_async/p2", out_p2, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'($urandom), 6'($urandom), 8'($urandom), 1'($urandom), 6'($urandom), 8'($urandom));
      @(posedge clk);
      #1;
      check("reset_held/p1", out_p1, 8'h00);
      check("reset_held/p2", out_p2, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    held1 = 8'h00;
    held2 = 8'h00;

    // Table-driven vectors. Ports that write must hold their previous output.
    for (int i = 0; i < 9; i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i].wr1, vecs[i].a1, vecs[i].d1, vecs[i].wr2, vecs[i].a2, vecs[i].d2);
      e.name = vecs[i].name;
      e.e1   = vecs[i].wr1 ? held1 : vecs[i].e1;
      e.e2   = vecs[i].wr2 ? held2 : vecs[i].e2;
      held1  = e.e1;
      held2  = e.e2;
      sb.push_back(e);
      @(posedge clk);
      #1;
      compare_front();
    end

    // Confirm the collision write landed: 0x02 must now hold 0x10.
    @(negedge clk);
    drive(1'b0, 6'h02, 8'h00, 1'b0, 6'h3F, 8'h00);
    sb.push_back('{"post_coll_read", 8'h10, 8'h5A});
    @(posedge clk);
    #1;
    compare_front();

    // Reset asserted before an edge that carries a write of 0x77 to 0x05.
    @(negedge clk);
    drive(1'b1, 6'h05, 8'h77, 1'b0, 6'h05, 8'h00);
    rst_n = 1'b0;
    #1;
    check("rst_mid_async/p1", out_p1, 8'h00);
    check("rst_mid_async/p2", out_p2, 8'h00);
    @(posedge clk);
    #1;
    check("rst_mid_edge/p1", out_p1, 8'h00);
    check("rst_mid_edge/p2", out_p2, 8'h00);

    // The first edge after release performs a normal read; 0x05 still holds 0x11.
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 6'h05, 8'h00, 1'b0, 6'h05, 8'h00);
    sb.push_back('{"rst_write_blocked", 8'h11, 8'h11});
    @(posedge clk);
    #1;
    compare_front();

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
